// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences the shared ALU,
// the unified memory port and the register file for LW/SW/R/I/BEQ/JAL.
module rv_multicycle_ctrl #(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_write,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [3:0] o_alu_op,
  output logic [1:0] o_result_src,
  output logic [1:0] o_imm_src,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11
  } state_t;

  state_t state_reg, state_next;

  function automatic logic [3:0] logic_op(input logic [2:0] f3);
    case (f3)
      3'b111:  logic_op = ALU_AND;
      3'b110:  logic_op = ALU_OR;
      3'b100:  logic_op = ALU_XOR;
      default: logic_op = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_reg <= RESET_STATE_FETCH ? S_FETCH : S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    o_mem_req    = 1'b0;
    o_mem_write  = 1'b0;
    o_adr_src    = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_alu_op     = ALU_ADD;
    o_result_src = 2'b00;
    o_imm_src    = 2'b00;
    o_illegal    = 1'b0;
    case (state_reg)
      S_IDLE: if (i_start) state_next = S_FETCH;
      S_FETCH: begin
        o_mem_req    = 1'b1;
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU computes oldPC + B-immediate here so BEQ finds its target in ALUOut
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
        o_imm_src   = 2'b10;
        case (i_opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_B:         state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            o_illegal  = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        if (i_opcode == OP_SW) begin
          o_imm_src  = 2'b01;
          state_next = S_MEMWRITE;
        end else begin
          state_next = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        o_mem_req = 1'b1;
        o_adr_src = 1'b1;
        if (i_mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_result_src = 2'b01;
        o_reg_write  = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        o_mem_req   = 1'b1;
        o_mem_write = 1'b1;
        o_adr_src   = 1'b1;
        if (i_mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = (i_funct3 == 3'b000 && i_funct7b5) ? ALU_SUB : logic_op(i_funct3);
        state_next  = S_ALUWB;
      end
      S_EXECI: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        o_alu_op    = logic_op(i_funct3);
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        o_reg_write = 1'b1;
        state_next  = S_FETCH;
      end
      S_BEQ: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = ALU_SUB;
        o_pc_write  = i_zero;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        o_pc_write  = 1'b1;
        state_next  = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
    // Reset abandons any in-flight access: no request and no architectural write
    if (!i_rst_n) begin
      o_mem_req   = 1'b0;
      o_mem_write = 1'b0;
      o_ir_write  = 1'b0;
      o_pc_write  = 1'b0;
      o_reg_write = 1'b0;
      o_illegal   = 1'b0;
    end
  end

  assign o_state = state_reg;

endmodule
